// File: rtl/alu_pkg.sv
// Shared constants and types for the CP-1 ALU datapath.
// Execution units default their width to ALU_WIDTH and exchange alu_word_t values.
package alu_pkg;

  localparam int ALU_WIDTH = 32;

  typedef logic [ALU_WIDTH-1:0] alu_word_t;

endpackage : alu_pkg

// File: rtl/bitwise_or_core.sv
// Purely combinational bitwise OR with zero and all-ones status flags.
// Each result bit depends only on the matching operand bits; no carries.
module bitwise_or_core
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             ones
);

  logic [WIDTH-1:0] w_y;

  assign w_y  = a | b;
  assign y    = w_y;
  assign zero = (w_y == '0);
  assign ones = &w_y;

endmodule : bitwise_or_core

// File: rtl/bitwise_or_unit.sv
// Registered bitwise-OR execution unit with valid/ready handshake on both sides.
// A single output register holds the result and flags until downstream consumes it.
module bitwise_or_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out,
  output logic             out_zero,
  output logic             out_ones,
  output logic             out_valid,
  input  logic             out_ready
);

  logic [WIDTH-1:0] w_y;
  logic             w_zero;
  logic             w_ones;
  logic             w_accept;

  logic [WIDTH-1:0] r_out;
  logic             r_zero;
  logic             r_ones;
  logic             r_valid;

  bitwise_or_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .a   (in0),
    .b   (in1),
    .y   (w_y),
    .zero(w_zero),
    .ones(w_ones)
  );

  // The register can take a new result when empty or when its current one leaves this cycle.
  assign in_ready = !r_valid || out_ready;
  assign w_accept = in_valid && in_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_out   <= '0;
      r_zero  <= 1'b0;
      r_ones  <= 1'b0;
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_out   <= w_y;
      r_zero  <= w_zero;
      r_ones  <= w_ones;
      r_valid <= 1'b1;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign out       = r_out;
  assign out_zero  = r_zero;
  assign out_ones  = r_ones;
  assign out_valid = r_valid;

endmodule : bitwise_or_unit

// File: tb/tb_bitwise_or_unit.sv
// Scoreboard bench for bitwise_or_unit: a handshake model queues expected results,
// a negedge monitor compares them; directed steps add hand-computed checks.
module tb_bitwise_or_unit;
  import alu_pkg::*;

  typedef struct packed {
    alu_word_t data;
    logic      zero;
    logic      ones;
  } exp_t;

  logic      clock = 1'b0;
  logic      reset_n = 1'b0;
  alu_word_t in0 = '0;
  alu_word_t in1 = '0;
  logic      in_valid = 1'b0;
  logic      in_ready;
  alu_word_t out;
  logic      out_zero;
  logic      out_ones;
  logic      out_valid;
  logic      out_ready = 1'b0;

  int   checks = 0;
  int   errors = 0;
  exp_t sbQueue[$];
  logic modelValid = 1'b0;
  exp_t lastSeen = '0;

  always #5 clock = ~clock;

  bitwise_or_unit #(
    .WIDTH(32)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .in0      (in0),
    .in1      (in1),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out      (out),
    .out_zero (out_zero),
    .out_ones (out_ones),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input alu_word_t a, input alu_word_t b,
                               input logic v, input logic rdy);
    in0       = a;
    in1       = b;
    in_valid  = v;
    out_ready = rdy;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Handshake model: pushes the expected result on every accept it predicts.
  initial begin
    exp_t item;
    logic accept;
    forever begin
      @(posedge clock or negedge reset_n);
      if (!reset_n) begin
        sbQueue.delete();
        modelValid = 1'b0;
        lastSeen   = '0;
      end else begin
        accept = in_valid && (!modelValid || out_ready);
        if (accept) begin
          item.data = in0 | in1;
          item.zero = ((in0 | in1) == 32'h0000_0000);
          item.ones = ((in0 | in1) == 32'hFFFF_FFFF);
          sbQueue.push_back(item);
        end
        modelValid = accept || (modelValid && !out_ready);
      end
    end
  end

  // Monitor: compares the presented result against the queue head, pops on consume.
  initial begin
    exp_t front;
    forever begin
      @(negedge clock);
      if (reset_n) begin
        checkOutput("mon_out_valid", {31'b0, out_valid}, {31'b0, modelValid});
        checkOutput("mon_in_ready", {31'b0, in_ready}, {31'b0, (!modelValid || out_ready)});
        if (modelValid) begin
          if (sbQueue.size() == 0) begin
            checkOutput("mon_queue_nonempty", 32'd0, 32'd1);
          end else begin
            front = sbQueue[0];
            checkOutput("mon_out", out, front.data);
            checkOutput("mon_zero", {31'b0, out_zero}, {31'b0, front.zero});
            checkOutput("mon_ones", {31'b0, out_ones}, {31'b0, front.ones});
            if (out_ready) begin
              lastSeen = front;
              void'(sbQueue.pop_front());
            end
          end
        end else begin
          checkOutput("mon_idle_out_hold", out, lastSeen.data);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors %0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    alu_word_t a;
    alu_word_t b;

    #1;
    checkOutput("reset_out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("reset_out", out, 32'h0000_0000);
    checkOutput("reset_flags", {30'b0, out_zero, out_ones}, 32'd0);
    checkOutput("reset_in_ready", {31'b0, in_ready}, 32'd1);
    repeat (2) @(posedge clock);
    #2 reset_n = 1'b1;

    // Directed vectors, each visible one cycle after accept, back to back.
    applyStimulus(32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1);
    step();
    checkOutput("dir0_out", out, 32'h0000_0000);
    checkOutput("dir0_valid", {31'b0, out_valid}, 32'd1);
    checkOutput("dir0_flags", {30'b0, out_zero, out_ones}, 32'b10);
    applyStimulus(32'hF0F0_F0F0, 32'h0F0F_0F0F, 1'b1, 1'b1);
    step();
    checkOutput("dir1_out", out, 32'hFFFF_FFFF);
    checkOutput("dir1_valid", {31'b0, out_valid}, 32'd1);
    checkOutput("dir1_flags", {30'b0, out_zero, out_ones}, 32'b01);
    applyStimulus(32'h1234_5678, 32'h8000_0001, 1'b1, 1'b1);
    step();
    checkOutput("dir2_out", out, 32'h9234_5679);
    checkOutput("dir2_valid", {31'b0, out_valid}, 32'd1);
    checkOutput("dir2_flags", {30'b0, out_zero, out_ones}, 32'b00);

    // Idle after consume: valid drops, value held.
    applyStimulus(32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1);
    step();
    checkOutput("idle_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("idle_out_hold", out, 32'h9234_5679);

    // Backpressure: result held, new operands refused while stalled.
    applyStimulus(32'hA5A5_0000, 32'h0000_5A5A, 1'b1, 1'b1);
    step();
    checkOutput("bp_out", out, 32'hA5A5_5A5A);
    applyStimulus(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      checkOutput("bp_hold_out", out, 32'hA5A5_5A5A);
      checkOutput("bp_hold_valid", {31'b0, out_valid}, 32'd1);
      checkOutput("bp_in_ready", {31'b0, in_ready}, 32'd0);
      checkOutput("bp_hold_flags", {30'b0, out_zero, out_ones}, 32'b00);
    end
    applyStimulus(32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1);
    step();
    checkOutput("bp_consumed_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("bp_consumed_out", out, 32'hA5A5_5A5A);

    // Simultaneous consume and accept: no bubble.
    applyStimulus(32'h0000_0000, 32'h0000_0010, 1'b1, 1'b1);
    step();
    checkOutput("sim_first_out", out, 32'h0000_0010);
    applyStimulus(32'h0000_0001, 32'h0000_0002, 1'b1, 1'b1);
    step();
    checkOutput("sim_out", out, 32'h0000_0003);
    checkOutput("sim_valid", {31'b0, out_valid}, 32'd1);

    // Back-to-back random operands, one result per cycle.
    for (int i = 0; i < 8; i++) begin
      a = $urandom;
      b = $urandom;
      applyStimulus(a, b, 1'b1, 1'b1);
      step();
      checkOutput("b2b_out", out, a | b);
      checkOutput("b2b_valid", {31'b0, out_valid}, 32'd1);
    end
    applyStimulus(32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1);
    step();
    checkOutput("b2b_drain_valid", {31'b0, out_valid}, 32'd0);

    // Mid-stream reset with a held result, then a fresh accept.
    applyStimulus(32'h0000_0055, 32'h0000_0000, 1'b1, 1'b0);
    step();
    checkOutput("rst_pre_valid", {31'b0, out_valid}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("rst_async_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("rst_async_out", out, 32'h0000_0000);
    checkOutput("rst_async_flags", {30'b0, out_zero, out_ones}, 32'd0);
    applyStimulus(32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1);
    @(posedge clock);
    #2 reset_n = 1'b1;
    applyStimulus(32'h1234_0000, 32'h0000_ABCD, 1'b1, 1'b1);
    step();
    checkOutput("rst_after_out", out, 32'h1234_ABCD);
    checkOutput("rst_after_valid", {31'b0, out_valid}, 32'd1);
    applyStimulus(32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1);
    step();
    step();
    checkOutput("end_queue_empty", sbQueue.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_bitwise_or_unit
